// File: rtl/vga_stream_out_pkg.sv
// vga_stream_out shared package: command codes, controller states,
// colour-bar table and default VGA 640x480 timing.
package vga_pack;

  localparam logic [3:0] CMD_START     = 4'h1;
  localparam logic [3:0] CMD_STOP      = 4'h2;
  localparam logic [3:0] CMD_CLEAR_ERR = 4'h3;
  localparam logic [3:0] CMD_PATTERN   = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } vga_state_t;

  // index 0 is the left-most bar
  localparam logic [0:7][11:0] BAR_RGB = {
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_stream_out_if.sv
// Pixel stream + command bus into vga_stream_out.
// master drives pixels/commands, slave returns Data_VGA_Ready.
interface vga_stream_out_if;
  logic [11:0] Data_VGA;
  logic        Data_VGA_Valid;
  logic        Data_VGA_Ready;
  logic [3:0]  VGA_Notification;
  logic        VGA_Notification_Valid;

  modport master (
    output Data_VGA, Data_VGA_Valid,
    output VGA_Notification, VGA_Notification_Valid,
    input  Data_VGA_Ready
  );

  modport slave (
    input  Data_VGA, Data_VGA_Valid,
    input  VGA_Notification, VGA_Notification_Valid,
    output Data_VGA_Ready
  );
endinterface

// File: rtl/vga_stream_out_sync_fifo.sv
// sync_fifo: single-clock FIFO, async active-high reset.
// Ports: push/din, pop/dout (show-ahead), full (registered), empty, count.
module sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_nxt;
  logic          wr_en, rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    unique case ({wr_en, rd_en})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/vga_stream_out.sv
// vga_stream_out: buffers the CM pixel stream and scans it out with VGA
// timing, one pixel per clk. Ports: clk, rst (async, active-high),
// bus (slave: pixels, commands, Data_VGA_Ready), Hsync/Vsync (active-low),
// Red/Green/Blue, Frame_Start, Underflow (sticky), State.
// Optional macro VGA_TEST_PATTERN_EN adds a colour-bar pattern mode.
module vga_stream_out
  import vga_pack::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic            clk,
  input  logic            rst,
  vga_stream_out_if.slave bus,
  output logic            Hsync,
  output logic            Vsync,
  output logic [3:0]      Red,
  output logic [3:0]      Green,
  output logic [3:0]      Blue,
  output logic            Frame_Start,
  output logic            Underflow,
  output logic [1:0]      State
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  vga_state_t    st;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   hx, vx;

  logic [11:0]   f_dout;
  logic          f_full, f_empty;
  logic [CW-1:0] f_count;

  logic          push, pop, under, primed;
  logic          scan, active, line_end, frame_end;
  logic          c_start, c_stop, c_clr;
  logic [11:0]   px;

  assign hx = 32'(h_cnt);
  assign vx = 32'(v_cnt);

  assign c_start = bus.VGA_Notification_Valid
                && bus.VGA_Notification == CMD_START;
  assign c_stop  = bus.VGA_Notification_Valid
                && bus.VGA_Notification == CMD_STOP;
  assign c_clr   = bus.VGA_Notification_Valid
                && bus.VGA_Notification == CMD_CLEAR_ERR;

  assign bus.Data_VGA_Ready = !f_full;
  assign push = bus.Data_VGA_Valid && bus.Data_VGA_Ready;

  assign scan      = (st == ST_RUN) || (st == ST_STOPPING);
  assign active    = scan && hx < H_ACTIVE && vx < V_ACTIVE;
  assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));

`ifdef VGA_TEST_PATTERN_EN
  logic       pat_q;
  logic [2:0] bar;

  assign bar    = 3'((hx * 8) / H_ACTIVE);
  assign pop    = active && !pat_q && !f_empty;
  assign under  = active && !pat_q && f_empty;
  // bars need no buffered data, so priming is skipped in pattern mode
  assign primed = pat_q || (32'(f_count) >= PRIME_LEVEL);

  always_comb begin
    px = 12'h000;
    if (active && pat_q)        px = BAR_RGB[bar];
    else if (active && !f_empty) px = f_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pat_q <= 1'b0;
    else if (bus.VGA_Notification_Valid
          && bus.VGA_Notification == CMD_PATTERN)
      pat_q <= !pat_q;
  end
`else
  assign pop    = active && !f_empty;
  assign under  = active && f_empty;
  assign primed = (32'(f_count) >= PRIME_LEVEL);

  always_comb begin
    px = 12'h000;
    if (active && !f_empty) px = f_dout;
  end
`endif

  sync_fifo #(
    .W     (12),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.Data_VGA),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // counters stay 0 outside scanning, so PRIME->RUN starts at (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      unique case (st)
        ST_IDLE:     if (c_start) st <= ST_PRIME;
        ST_PRIME:    if (c_stop) st <= ST_IDLE;
                     else if (primed) st <= ST_RUN;
        ST_RUN:      if (c_stop) st <= ST_STOPPING;
        ST_STOPPING: if (c_start) st <= ST_RUN;
                     else if (frame_end) st <= ST_IDLE;
        default:     st <= ST_IDLE;
      endcase
      if (scan) begin
        h_cnt <= line_end ? '0 : h_cnt + 1'b1;
        if (line_end) v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= '0;
        v_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      Red         <= '0;
      Green       <= '0;
      Blue        <= '0;
      Frame_Start <= 1'b0;
      Underflow   <= 1'b0;
    end else begin
      Hsync <= !(scan && hx >= H_ACTIVE + H_FP
                      && hx < H_ACTIVE + H_FP + H_SYNC);
      Vsync <= !(scan && vx >= V_ACTIVE + V_FP
                      && vx < V_ACTIVE + V_FP + V_SYNC);
      {Red, Green, Blue} <= px;
      Frame_Start <= scan && h_cnt == '0 && v_cnt == '0;
      if (under)      Underflow <= 1'b1;
      else if (c_clr) Underflow <= 1'b0;
    end
  end

  assign State = st;

endmodule

// File: tb/tb_vga_stream_out.sv
// tb_vga_stream_out: directed sequence with random data/noise, checked
// every cycle against a scan-position reference model.
module tb_vga_stream_out;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int DEPTH = 16;
  localparam int PL = 4;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs, vs, fs, uf;
  logic [3:0] r, g, b;
  logic [1:0] st;

  vga_stream_out_if bus();

  vga_stream_out #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .FIFO_DEPTH (DEPTH), .PRIME_LEVEL (PL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .Hsync       (hs),
    .Vsync       (vs),
    .Red         (r),
    .Green       (g),
    .Blue        (b),
    .Frame_Start (fs),
    .Underflow   (uf),
    .State       (st)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: state, linear scan position, pixel queue
  int          m_st;
  int          m_pos;
  logic [11:0] q [$];
  logic        m_uf, m_pat;
  logic        e_hs, e_vs, e_fs;
  logic [11:0] e_rgb;
  bit          seen;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_pos = 0;
    q.delete();
    m_uf  = 1'b0;
    m_pat = 1'b0;
  endtask

  task automatic step(input logic v, input logic [11:0] d,
                      input logic [3:0] c, input logic cv);
    int h, vv, n;
    bit scn, act, c_st, c_sp, c_cl, c_pt;
    bus.Data_VGA_Valid = v;
    bus.Data_VGA = d;
    bus.VGA_Notification = c;
    bus.VGA_Notification_Valid = cv;
    h    = m_pos % HT;
    vv   = m_pos / HT;
    n    = q.size();
    scn  = (m_st >= 2);
    act  = scn && h < HA && vv < VA;
    c_st = cv && c == 4'h1;
    c_sp = cv && c == 4'h2;
    c_cl = cv && c == 4'h3;
    c_pt = cv && c == 4'h4;
    e_hs = !(scn && h >= HA + HF && h < HA + HF + HS);
    e_vs = !(scn && vv >= VA + VF && vv < VA + VF + VS);
    e_fs = scn && m_pos == 0;
    e_rgb = 12'h000;
    if (act && m_pat) begin
`ifdef VGA_TEST_PATTERN_EN
      e_rgb = BARS[h * 8 / HA];
`endif
    end else if (act && n > 0) begin
      e_rgb = q.pop_front();
    end
    if (act && !m_pat && n == 0) m_uf = 1'b1;
    else if (c_cl) m_uf = 1'b0;
    if (v && n < DEPTH) q.push_back(d);
    case (m_st)
      0: if (c_st) m_st = 1;
      1: if (c_sp) m_st = 0;
         else if (n >= PL || m_pat) m_st = 2;
      2: if (c_sp) m_st = 3;
      default: if (c_st) m_st = 2;
               else if (m_pos == FT - 1) m_st = 0;
    endcase
    m_pos = scn ? (m_pos + 1) % FT : 0;
`ifdef VGA_TEST_PATTERN_EN
    if (c_pt) m_pat = !m_pat;
`else
    if (c_pt) m_pat = m_pat;
`endif
    @(posedge clk);
    #1;
    check("state", 16'(st), 16'(m_st));
    check("hsync", 16'(hs), 16'(e_hs));
    check("vsync", 16'(vs), 16'(e_vs));
    check("rgb", 16'({r, g, b}), 16'(e_rgb));
    check("frame_start", 16'(fs), 16'(e_fs));
    check("underflow", 16'(uf), 16'(m_uf));
    check("ready", 16'(bus.Data_VGA_Ready), 16'(q.size() != DEPTH));
  endtask

  // idle cycle with optional random push and an ignored noise command
  task automatic tick(input bit push_en);
    int k;
    logic [3:0] c;
    k = $urandom_range(0, 11);
    c = (k == 0) ? 4'h0 : 4'(k + 4);
    step(push_en && ($urandom_range(0, 1) == 1), 12'($urandom), c,
         $urandom_range(0, 3) == 0);
  endtask

  task automatic mid_reset(input string tag);
    bus.Data_VGA_Valid = 1'b0;
    bus.VGA_Notification_Valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_state"}, 16'(st), 16'd0);
    check({tag, "_hsync"}, 16'(hs), 16'd1);
    check({tag, "_vsync"}, 16'(vs), 16'd1);
    check({tag, "_rgb"}, 16'({r, g, b}), 16'h000);
    check({tag, "_fs"}, 16'(fs), 16'd0);
    check({tag, "_uf"}, 16'(uf), 16'd0);
    check({tag, "_ready"}, 16'(bus.Data_VGA_Ready), 16'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.Data_VGA = '0;
    bus.Data_VGA_Valid = 1'b0;
    bus.VGA_Notification = '0;
    bus.VGA_Notification_Valid = 1'b0;
    model_reset();
    #12;
    check("rst_state", 16'(st), 16'd0);
    check("rst_hsync", 16'(hs), 16'd1);
    check("rst_vsync", 16'(vs), 16'd1);
    check("rst_rgb", 16'({r, g, b}), 16'h000);
    check("rst_fs", 16'(fs), 16'd0);
    check("rst_uf", 16'(uf), 16'd0);
    check("rst_ready", 16'(bus.Data_VGA_Ready), 16'd1);
    @(negedge clk);
    rst = 1'b0;

    // pixels 1..12, then START; 2nd frame drains into underflow
    for (int i = 1; i <= 12; i++) step(1'b1, 12'(i), 4'h0, 1'b0);
    step(1'b0, 12'h0, 4'h1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 2 * FT; k++) begin
      step(1'b0, 12'h0, 4'h0, 1'b0);
      if (fs && !seen) begin
        seen = 1'b1;
        check("fs_first_pix", 16'({r, g, b}), 16'h001);
      end
    end
    check("fs_seen", 16'(seen), 16'd1);
    check("uf_after_drain", 16'(uf), 16'd1);

    // async reset mid-line at h_cnt=3
    for (int k = 0; k < HT && (m_pos % HT) != 3; k++) tick(1'b0);
    mid_reset("arst");

    // 5 pixels only, underflow, clear attempts racing underflow
    for (int i = 0; i < 5; i++) step(1'b1, 12'($urandom), 4'h0, 1'b0);
    step(1'b0, 12'h0, 4'h1, 1'b1);
    for (int k = 0; k < FT; k++) tick(1'b0);
    check("uf_set", 16'(uf), 16'd1);
    for (int k = 0; k < FT; k++) begin
      if (k % 3 == 0) step(1'b0, 12'h0, 4'h3, 1'b1);
      else tick(1'b0);
    end
    step(1'b0, 12'h0, 4'h2, 1'b1);
    for (int k = 0; k < 2 * FT && st != 2'd0; k++) tick(1'b0);
    check("stop_idle", 16'(st), 16'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 12'($urandom), 4'h0, 1'b0);
    step(1'b0, 12'h0, 4'h3, 1'b1);
    check("uf_cleared", 16'(uf), 16'd0);

    // STOP at v_cnt=2, START while stopping, then STOP to idle
    step(1'b0, 12'h0, 4'h1, 1'b1);
    for (int k = 0; k < 3 * FT && !(m_st == 2 && m_pos == 2 * HT); k++)
      tick(1'b1);
    step(1'b0, 12'h0, 4'h2, 1'b1);
    check("stopping", 16'(st), 16'd3);
    for (int k = 0; k < HT; k++) tick(1'b1);
    step(1'b0, 12'h0, 4'h1, 1'b1);
    check("restart_run", 16'(st), 16'd2);
    for (int k = 0; k < 5; k++) tick(1'b1);
    step(1'b0, 12'h0, 4'h2, 1'b1);
    for (int k = 0; k < 2 * FT && st != 2'd0; k++) tick(1'b1);
    check("final_idle", 16'(st), 16'd0);
    check("idle_hsync", 16'(hs), 16'd1);
    check("idle_vsync", 16'(vs), 16'd1);

    // fill with no START: Ready drops after 16 accepted
    mid_reset("arst2");
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 12'($urandom), 4'h0, 1'b0);
      if (k == 15) check("ready_low_at16", 16'(bus.Data_VGA_Ready), 16'd0);
    end
    step(1'b0, 12'h0, 4'h1, 1'b1);
    for (int k = 0; k < FT; k++) tick(1'b0);

`ifdef VGA_TEST_PATTERN_EN
    mid_reset("arst3");
    step(1'b0, 12'h0, 4'h4, 1'b1);
    step(1'b0, 12'h0, 4'h1, 1'b1);
    for (int k = 0; k < FT + 4; k++) tick(1'b0);
    check("pat_no_uf", 16'(uf), 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
